// File: rtl/ascii2hex_pkg.sv
// Shared constants, state encoding and a range helper for the ASCII-to-hex
// stream packer and its character decoder.
package ascii2hex_pkg;

    localparam logic [6:0] ASCII_0   = 7'h30;
    localparam logic [6:0] ASCII_9   = 7'h39;
    localparam logic [6:0] ASCII_UA  = 7'h41;
    localparam logic [6:0] ASCII_UF  = 7'h46;
    localparam logic [6:0] ASCII_LA  = 7'h61;
    localparam logic [6:0] ASCII_LF_ = 7'h66;
    localparam logic [6:0] ASCII_NL  = 7'h0A;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        OUT   = 2'd1,
        ERR   = 2'd2
    } state_t;

    // True when c lies in the inclusive code range [lo, hi].
    function automatic logic in_range(input logic [6:0] c,
                                      input logic [6:0] lo,
                                      input logic [6:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/ascii_nibble_decode.sv
// Combinational ASCII character classifier: maps '0'-'9' / 'A'-'F' to a
// nibble and flags line feed. Lowercase 'a'-'f' is accepted only when the
// LOWERCASE_EN macro is defined; otherwise it is reported as non-hex.
module ascii_nibble_decode
    import ascii2hex_pkg::*;
(
    input  logic [6:0] in_char,
    output logic       is_hex,
    output logic       is_nl,
    output logic [3:0] nib
);

    logic [6:0] ofs_s;

    // Classify the character and compute its nibble value from the code offset.
    always_comb begin
        is_hex = 1'b0;
        is_nl  = 1'b0;
        ofs_s  = 7'h00;
        if (in_range(in_char, ASCII_0, ASCII_9)) begin
            is_hex = 1'b1;
            ofs_s  = in_char - ASCII_0;
        end else if (in_range(in_char, ASCII_UA, ASCII_UF)) begin
            is_hex = 1'b1;
            ofs_s  = in_char - ASCII_UA + 7'd10;
`ifdef LOWERCASE_EN
        end else if (in_range(in_char, ASCII_LA, ASCII_LF_)) begin
            is_hex = 1'b1;
            ofs_s  = in_char - ASCII_LA + 7'd10;
`endif
        end else if (in_char == ASCII_NL) begin
            is_nl = 1'b1;
        end else begin
            is_hex = 1'b0;
            is_nl  = 1'b0;
        end
        nib = ofs_s[3:0];
    end

endmodule

// File: rtl/ascii2hex_stream.sv
// Streaming ASCII hex digit packer. Collects NIBBLES hex digits MSB-first into
// one right-justified word; a line feed flushes a partial word and any other
// character produces an error token. The result is held on the output until
// consumed, and no input is accepted meanwhile.
// Optional feature macro: LOWERCASE_EN (accept 'a'-'f' as hex digits).
module ascii2hex_stream
    import ascii2hex_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [6:0]                       in_char,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [4*NIBBLES-1:0]             out_word,
    output logic [$clog2(NIBBLES+1)-1:0]     out_len,
    output logic                             out_err
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    state_t          state_r, state_n;
    logic [W-1:0]    acc_r, acc_n;
    logic [CW-1:0]   count_r, count_n;
    logic [W+3:0]    shifted_s;
    logic [CW-1:0]   count_inc_s;
    logic            is_hex_s, is_nl_s;
    logic [3:0]      nib_s;
    logic            accept_s;
    logic            out_valid_n, in_ready_n, out_err_n;
    logic [W-1:0]    out_word_n;
    logic [CW-1:0]   out_len_n;

    ascii_nibble_decode u_decode (
        .in_char (in_char),
        .is_hex  (is_hex_s),
        .is_nl   (is_nl_s),
        .nib     (nib_s)
    );

    // Shift the new nibble in at the bottom; the wide intermediate keeps this
    // well-formed even for a single-nibble word.
    assign shifted_s   = {acc_r, nib_s};
    assign count_inc_s = count_r + CW'(1'b1);
    assign accept_s    = in_valid && in_ready;

    // Next-state, accumulator and digit-count logic.
    always_comb begin
        state_n = state_r;
        acc_n   = acc_r;
        count_n = count_r;
        case (state_r)
            ACCUM: begin
                if (accept_s) begin
                    if (is_hex_s) begin
                        acc_n   = shifted_s[W-1:0];
                        count_n = count_inc_s;
                        if (count_inc_s == CW'(NIBBLES)) begin
                            state_n = OUT;
                        end else begin
                            state_n = ACCUM;
                        end
                    end else if (is_nl_s) begin
                        if (count_r != {CW{1'b0}}) begin
                            state_n = OUT;
                        end else begin
                            state_n = ACCUM;
                        end
                    end else begin
                        state_n = ERR;
                    end
                end else begin
                    state_n = ACCUM;
                end
            end
            OUT, ERR: begin
                if (out_ready) begin
                    state_n = ACCUM;
                    acc_n   = {W{1'b0}};
                    count_n = {CW{1'b0}};
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ACCUM;
                acc_n   = {W{1'b0}};
                count_n = {CW{1'b0}};
            end
        endcase
    end

    // Output values for the upcoming state, registered below so outputs stay
    // glitch-free and stable while a result is held.
    always_comb begin
        out_valid_n = 1'b0;
        in_ready_n  = 1'b1;
        out_err_n   = 1'b0;
        out_word_n  = {W{1'b0}};
        out_len_n   = {CW{1'b0}};
        case (state_n)
            ACCUM: begin
                in_ready_n = 1'b1;
            end
            OUT: begin
                out_valid_n = 1'b1;
                in_ready_n  = 1'b0;
                out_word_n  = acc_n;
                out_len_n   = count_n;
            end
            ERR: begin
                out_valid_n = 1'b1;
                in_ready_n  = 1'b0;
                out_err_n   = 1'b1;
            end
            default: begin
                in_ready_n = 1'b1;
            end
        endcase
    end

    // State, accumulator and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ACCUM;
            acc_r   <= {W{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            state_r <= state_n;
            acc_r   <= acc_n;
            count_r <= count_n;
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_err   <= 1'b0;
            out_word  <= {W{1'b0}};
            out_len   <= {CW{1'b0}};
        end else begin
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
            out_err   <= out_err_n;
            out_word  <= out_word_n;
            out_len   <= out_len_n;
        end
    end

endmodule
